// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ===========================================================================
// ram_port_arbiter : round-robin arbiter sharing one single-port RAM between
//                    two requesters (IDLE -> CMD -> RESP per access).
// Revision 1.0
// ===========================================================================
module ram_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int NUMWORDS = 4096
) (
  input  logic              clock0,
  input  logic              aclr0,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic              err_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [ADDR_W:0] c_numwords = (ADDR_W+1)'(NUMWORDS);

  logic [1:0]        r_state;
  // Granted port of the current/last access; reset to b so a wins the first tie.
  logic              r_gnt_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  logic              w_sel_b;
  logic              w_oor;
  logic              w_cmd;
  logic              w_resp;
  logic [DATA_W-1:0] w_rd_val;

  assign w_sel_b  = req_b & (~req_a | ~r_gnt_b);
  assign w_oor    = ({1'b0, r_addr} >= c_numwords);
  assign w_cmd    = (r_state == CMD);
  assign w_resp   = (r_state == RESP);
  assign w_rd_val = w_oor ? '0 : ram_q;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_state   <= IDLE;
      r_gnt_b   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_a | req_b) begin
            r_state <= CMD;
            r_gnt_b <= w_sel_b;
            r_we    <= w_sel_b ? we_b    : we_a;
            r_addr  <= w_sel_b ? addr_b  : addr_a;
            r_wdata <= w_sel_b ? wdata_b : wdata_a;
          end
        end
        CMD: r_state <= RESP;
        RESP: begin
          r_state <= IDLE;
          if (!r_we) begin
            if (r_gnt_b) r_rdata_b <= w_rd_val;
            else         r_rdata_a <= w_rd_val;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset term keeps an aborted write from reaching the RAM at the next edge.
  assign ram_wren    = w_cmd & ~w_oor &  r_we & ~aclr0;
  assign ram_rden    = w_cmd & ~w_oor & ~r_we & ~aclr0;
  assign ram_address = r_addr;
  assign ram_data    = r_wdata;
  assign busy        = (r_state != IDLE);

  assign ack_a   = w_resp & ~r_gnt_b;
  assign ack_b   = w_resp &  r_gnt_b;
  assign err_a   = ack_a & w_oor;
  assign err_b   = ack_b & w_oor;
  assign rdata_a = (ack_a & ~r_we) ? w_rd_val : r_rdata_a;
  assign rdata_b = (ack_b & ~r_we) ? w_rd_val : r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// Self-checking bench for ram_port_arbiter: directed cases then random
// accesses against a transaction-level model with a behavioural RAM.
module tb_ram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int NW = 3000;

  logic          clk = 1'b0;
  logic          aclr0 = 1'b1;
  logic          req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, err_a, ack_b, err_b, ram_wren, ram_rden, busy;
  logic [DW-1:0] rdata_a, rdata_b, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rd  [2];
  bit            last_b;
  int            vectors = 0;
  int            miscompares = 0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUMWORDS(NW)) dut (
    .clock0(clk), .aclr0(aclr0),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered output.
  always @(posedge clk) begin
    if (ram_rden) ram_q <= ram_mem[ram_address];
    if (ram_wren) ram_mem[ram_address] <= ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic do_reset();
    aclr0 = 1'b1;
    #1;
    chk("reset_ctl", {busy, ram_wren, ram_rden, ack_a, ack_b, err_a, err_b},
        7'b0);
    chk("reset_ram", {ram_address, ram_data}, '0);
    chk("reset_rd", {rdata_a, rdata_b}, '0);
    last_b = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(posedge clk);
    @(negedge clk);
    aclr0 = 1'b0;
  endtask

  task automatic idle_cycle();
    req_a = 0;
    req_b = 0;
    @(posedge clk);
    @(negedge clk);
    chk("idle", {busy, ack_a, ack_b, ram_wren, ram_rden}, 5'b0);
  endtask

  // One access from IDLE; returns at the negedge of the following IDLE cycle.
  task automatic xact(input logic ra, input logic rb,
                      input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    int            g;
    logic          we, oor;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, rv;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    g  = (ra && rb) ? int'(!last_b) : int'(rb);
    last_b = (g == 1);
    we = g ? wb : wa;
    ad = g ? ab : aa;
    wd = g ? db : da;
    oor = (int'(ad) >= NW);
    rv  = oor ? '0 : ref_mem[ad];
    @(posedge clk);
    // Inputs outside the IDLE sample edge must be ignored.
    #1;
    we_a = 1'($urandom); addr_a = AW'($urandom); wdata_a = DW'($urandom);
    we_b = 1'($urandom); addr_b = AW'($urandom); wdata_b = DW'($urandom);
    @(negedge clk);
    chk("cmd_ctl", {busy, ram_wren, ram_rden, ack_a, ack_b},
        {1'b1, we & ~oor, ~we & ~oor, 2'b00});
    chk("cmd_addr", {ram_address, ram_data}, {ad, wd});
    @(posedge clk);
    @(negedge clk);
    chk("resp_ctl", {busy, ram_wren, ram_rden, ack_a, ack_b, err_a, err_b},
        {3'b100, g == 0, g == 1, (g == 0) & oor, (g == 1) & oor});
    if (!we) exp_rd[g] = rv;
    else if (!oor) ref_mem[ad] = wd;
    chk("resp_rd", {rdata_a, rdata_b}, {exp_rd[0], exp_rd[1]});
    chk("resp_addr", {ram_address, ram_data}, {ad, wd});
    req_a = 0;
    req_b = 0;
    @(posedge clk);
    @(negedge clk);
    chk("done_ctl", {busy, ack_a, ack_b, ram_wren, ram_rden}, 5'b0);
    chk("done_rd", {rdata_a, rdata_b}, {exp_rd[0], exp_rd[1]});
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(NW, (1<<AW)-1));
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ram_mem[i] <= DW'(i * 37 + 5);
      ref_mem[i] =  DW'(i * 37 + 5);
    end
    @(negedge clk);
    do_reset();
    // Lone b right after reset: granted on the first edge.
    xact(0, 1, 0, '0, '0, 0, 12'd3, '0);

    do_reset();
    // Held tie of reads: a, b, a, b at 3-cycle spacing.
    for (int i = 0; i < 4; i++) begin
      xact(1, 1, 0, 12'd1, '0, 0, 12'd2, '0);
      chk("tie_order", {31'b0, last_b}, {31'b0, i[0] == 1'b1});
    end

    xact(1, 0, 1, 12'h010, 8'hA5, 0, '0, '0);
    xact(1, 0, 0, 12'h010, '0,    0, '0, '0);
    chk("wr_rd_a5", {24'b0, rdata_a}, 32'hA5);

    xact(1, 0, 1, 12'd9, 8'h11, 0, '0, '0);
    xact(1, 0, 0, 12'd9, '0,    0, '0, '0);
    xact(0, 1, 0, '0, '0, 1, 12'd5, 8'h3C);
    chk("iso_hold", {24'b0, rdata_a}, 32'h11);
    xact(1, 0, 0, 12'd5, '0, 0, '0, '0);
    chk("iso_read", {24'b0, rdata_a}, 32'h3C);

    xact(0, 1, 0, '0, '0, 0, AW'(NW), '0);
    chk("oor_rd", {24'b0, rdata_b}, 32'h0);

    // Reset while a write sits in CMD: no RAM write, no ack.
    req_a = 1; we_a = 1; addr_a = 12'd7; wdata_a = 8'hFF;
    @(posedge clk);
    #1 req_a = 0;
    @(negedge clk);
    chk("abort_wren_pre", {31'b0, ram_wren}, 32'd1);
    #2 aclr0 = 1'b1;
    #1;
    chk("abort_wren", {busy, ram_wren, ram_rden, ack_a}, 4'b0);
    chk("abort_ram", {ram_address, ram_data, rdata_a}, '0);
    last_b = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_noack", {ack_a, ack_b, busy}, 3'b0);
    aclr0 = 1'b0;
    xact(1, 0, 0, 12'd7, '0, 0, '0, '0);
    chk("abort_keep", {24'b0, rdata_a}, {24'b0, ref_mem[7]});

    for (int i = 0; i < 60; i++) begin
      int pat;
      pat = int'($urandom_range(0, 3));
      if (pat == 0) idle_cycle();
      else xact(pat[0], pat[1], 1'($urandom), rnd_addr(), DW'($urandom),
                1'($urandom), rnd_addr(), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
